// File: rtl/adc_channel_pack.sv
// Packs the samples of the enabled ADC channels into full-width FIFO words.
// Samples spill across word boundaries so that no sample is dropped or padded.
module adc_channel_pack #(
    parameter int NUM_OF_CHANNELS = 2,
    parameter int DATA_WIDTH      = 16
) (
    input  logic                                  adc_clk,
    input  logic                                  adc_rst,
    input  logic [NUM_OF_CHANNELS-1:0]            adc_enable,
    input  logic                                  adc_valid,
    input  logic [NUM_OF_CHANNELS*DATA_WIDTH-1:0] adc_data,
    input  logic                                  fifo_full,
    output logic                                  packed_wr,
    output logic [NUM_OF_CHANNELS*DATA_WIDTH-1:0] packed_data,
    output logic                                  packed_sync,
    output logic                                  adc_dovf
);

    localparam int N     = NUM_OF_CHANNELS;
    localparam int W     = DATA_WIDTH;
    localparam int DEPTH = 2 * N - 1;
    localparam int CW    = $clog2(2 * N);

    logic [W-1:0]   buf_q [DEPTH];
    logic [W-1:0]   buf_d [DEPTH];
    logic [W-1:0]   merged [DEPTH];
    logic [CW-1:0]  fill_q, fill_d;
    logic [N-1:0]   enable_q, enable_d;
    logic           sync_armed_q, sync_armed_d;
    logic           packed_wr_q, packed_wr_d;
    logic [N*W-1:0] packed_data_q, packed_data_d;
    logic           packed_sync_q, packed_sync_d;
    logic           adc_dovf_q, adc_dovf_d;

    logic           enable_changed;
    logic           armed;
    int             count;

    always_comb begin
        enable_d       = adc_enable;
        enable_changed = (adc_enable != enable_q);
        armed          = sync_armed_q | enable_changed;
        count          = enable_changed ? 0 : int'(fill_q);

        // An enable change drops the partial word before the new samples land.
        for (int j = 0; j < DEPTH; j++) begin
            merged[j] = enable_changed ? '0 : buf_q[j];
        end

        if (adc_valid && (|adc_enable)) begin
            for (int i = 0; i < N; i++) begin
                if (adc_enable[i]) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j == count) begin
                            merged[j] = adc_data[i*W +: W];
                        end
                    end
                    count = count + 1;
                end
            end
        end

        buf_d         = merged;
        fill_d        = CW'(count);
        sync_armed_d  = armed;
        packed_wr_d   = 1'b0;
        packed_data_d = packed_data_q;
        packed_sync_d = 1'b0;
        adc_dovf_d    = 1'b0;

        if (count >= N) begin
            for (int j = 0; j < N - 1; j++) begin
                buf_d[j] = merged[j+N];
            end
            for (int j = N - 1; j < DEPTH; j++) begin
                buf_d[j] = '0;
            end
            fill_d = CW'(count - N);

            // A dropped word keeps the sync marker for the next word that lands.
            if (fifo_full) begin
                adc_dovf_d = 1'b1;
            end else begin
                packed_wr_d   = 1'b1;
                packed_sync_d = armed;
                sync_armed_d  = 1'b0;
                for (int j = 0; j < N; j++) begin
                    packed_data_d[j*W +: W] = merged[j];
                end
            end
        end
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                buf_q[j] <= '0;
            end
            fill_q        <= '0;
            enable_q      <= '0;
            sync_armed_q  <= 1'b1;
            packed_wr_q   <= 1'b0;
            packed_data_q <= '0;
            packed_sync_q <= 1'b0;
            adc_dovf_q    <= 1'b0;
        end else begin
            buf_q         <= buf_d;
            fill_q        <= fill_d;
            enable_q      <= enable_d;
            sync_armed_q  <= sync_armed_d;
            packed_wr_q   <= packed_wr_d;
            packed_data_q <= packed_data_d;
            packed_sync_q <= packed_sync_d;
            adc_dovf_q    <= adc_dovf_d;
        end
    end

    assign packed_wr   = packed_wr_q;
    assign packed_data = packed_data_q;
    assign packed_sync = packed_sync_q;
    assign adc_dovf    = adc_dovf_q;

endmodule

// File: tb/tb_adc_channel_pack.sv
// Bench for adc_channel_pack: a 2-lane and a 4-lane instance checked against a
// queue-based sample-stream model plus hand-computed words.
module tb_adc_channel_pack;

    logic        clk;
    logic        rst;

    logic [1:0]  en2;
    logic        valid2;
    logic [31:0] data2;
    logic        full2;
    logic        wr2;
    logic [31:0] pd2;
    logic        sync2;
    logic        dovf2;

    logic [3:0]  en4;
    logic        valid4;
    logic [63:0] data4;
    logic        full4;
    logic        wr4;
    logic [63:0] pd4;
    logic        sync4;
    logic        dovf4;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    // The model views each instance as one flat sample queue cut into words.
    logic [15:0] mq [2][$];
    logic [7:0]  prev_en [2];
    bit          armed [2];
    logic        exp_wr [2];
    logic [63:0] exp_data [2];
    logic        exp_sync [2];
    logic        exp_dovf [2];

    adc_channel_pack #(.NUM_OF_CHANNELS(2), .DATA_WIDTH(16)) dut2 (
        .adc_clk     (clk),
        .adc_rst     (rst),
        .adc_enable  (en2),
        .adc_valid   (valid2),
        .adc_data    (data2),
        .fifo_full   (full2),
        .packed_wr   (wr2),
        .packed_data (pd2),
        .packed_sync (sync2),
        .adc_dovf    (dovf2)
    );

    adc_channel_pack #(.NUM_OF_CHANNELS(4), .DATA_WIDTH(16)) dut4 (
        .adc_clk     (clk),
        .adc_rst     (rst),
        .adc_enable  (en4),
        .adc_valid   (valid4),
        .adc_data    (data4),
        .fifo_full   (full4),
        .packed_wr   (wr4),
        .packed_data (pd4),
        .packed_sync (sync4),
        .adc_dovf    (dovf4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep(input int m, input int n, input logic [7:0] en, input logic valid,
                             input logic [127:0] data, input logic full);
        logic [63:0] word;
        if (rst) begin
            mq[m].delete();
            armed[m]    = 1'b1;
            prev_en[m]  = '0;
            exp_wr[m]   = 1'b0;
            exp_data[m] = '0;
            exp_sync[m] = 1'b0;
            exp_dovf[m] = 1'b0;
            return;
        end
        exp_wr[m]   = 1'b0;
        exp_sync[m] = 1'b0;
        exp_dovf[m] = 1'b0;
        if (en != prev_en[m]) begin
            mq[m].delete();
            armed[m] = 1'b1;
        end
        prev_en[m] = en;
        if (valid && en != 0) begin
            for (int i = 0; i < n; i++) begin
                if (en[i]) mq[m].push_back(data[i*16 +: 16]);
            end
        end
        if (mq[m].size() >= n) begin
            word = '0;
            for (int s = 0; s < n; s++) word[s*16 +: 16] = mq[m].pop_front();
            if (full) begin
                exp_dovf[m] = 1'b1;
            end else begin
                exp_wr[m]   = 1'b1;
                exp_data[m] = word;
                exp_sync[m] = armed[m];
                armed[m]    = 1'b0;
            end
        end
    endtask

    always @(posedge clk) begin
        modelStep(0, 2, {6'b0, en2}, valid2, {96'b0, data2}, full2);
        modelStep(1, 4, {4'b0, en4}, valid4, {64'b0, data4}, full4);
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("model wr2",   {63'b0, wr2},   {63'b0, exp_wr[0]});
            checkOutput("model data2", {32'b0, pd2},   exp_data[0]);
            checkOutput("model sync2", {63'b0, sync2}, {63'b0, exp_sync[0]});
            checkOutput("model dovf2", {63'b0, dovf2}, {63'b0, exp_dovf[0]});
            checkOutput("model wr4",   {63'b0, wr4},   {63'b0, exp_wr[1]});
            checkOutput("model data4", pd4,            exp_data[1]);
            checkOutput("model sync4", {63'b0, sync4}, {63'b0, exp_sync[1]});
            checkOutput("model dovf4", {63'b0, dovf4}, {63'b0, exp_dovf[1]});
        end
    end

    task automatic applyStimulus(input int m, input logic [3:0] e, input logic v,
                                 input logic [63:0] d, input logic f);
        if (m == 0) begin
            en2    = e[1:0];
            valid2 = v;
            data2  = d[31:0];
            full2  = f;
            valid4 = 1'b0;
            full4  = 1'b0;
        end else begin
            en4    = e;
            valid4 = v;
            data4  = d;
            full4  = f;
            valid2 = 1'b0;
            full2  = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] ren;
        rst = 1'b1;
        en2 = '0; valid2 = 1'b0; data2 = '0; full2 = 1'b0;
        en4 = '0; valid4 = 1'b0; data4 = '0; full4 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset wr2",   {63'b0, wr2},   64'd0);
        checkOutput("reset data2", {32'b0, pd2},   64'd0);
        checkOutput("reset sync2", {63'b0, sync2}, 64'd0);
        checkOutput("reset dovf2", {63'b0, dovf2}, 64'd0);
        rst = 1'b0;
        checking = 1'b1;

        // All lanes on: a full word every cycle, sync on the first only.
        applyStimulus(0, 4'b0011, 1'b1, 64'h2222_1111, 1'b0);
        checkOutput("full wr",    {63'b0, wr2},   64'd1);
        checkOutput("full data",  {32'b0, pd2},   64'h2222_1111);
        checkOutput("full sync1", {63'b0, sync2}, 64'd1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 4'b0011, 1'b1, 64'h2222_1111, 1'b0);
            checkOutput("full syncN", {63'b0, sync2}, 64'd0);
        end
        applyStimulus(0, 4'b0011, 1'b0, 64'h0, 1'b0);
        checkOutput("idle wr",   {63'b0, wr2}, 64'd0);
        checkOutput("hold data", {32'b0, pd2}, 64'h2222_1111);

        // Lane 1 only: two samples per word.
        applyStimulus(0, 4'b0010, 1'b1, 64'h000A_0000, 1'b0);
        checkOutput("half A wr", {63'b0, wr2}, 64'd0);
        applyStimulus(0, 4'b0010, 1'b1, 64'h000B_0000, 1'b0);
        checkOutput("half B data", {32'b0, pd2},   64'h000B_000A);
        checkOutput("half B sync", {63'b0, sync2}, 64'd1);
        applyStimulus(0, 4'b0010, 1'b1, 64'h000C_0000, 1'b0);
        checkOutput("half C wr", {63'b0, wr2}, 64'd0);
        applyStimulus(0, 4'b0010, 1'b1, 64'h000D_0000, 1'b0);
        checkOutput("half D data", {32'b0, pd2}, 64'h000D_000C);

        // Enable change discards the held partial sample.
        applyStimulus(0, 4'b0010, 1'b1, 64'h0005_0000, 1'b0);
        applyStimulus(0, 4'b0011, 1'b0, 64'h0, 1'b0);
        checkOutput("chg wr", {63'b0, wr2}, 64'd0);
        applyStimulus(0, 4'b0011, 1'b1, 64'h4444_3333, 1'b0);
        checkOutput("chg data", {32'b0, pd2},   64'h4444_3333);
        checkOutput("chg sync", {63'b0, sync2}, 64'd1);

        // Overflow on the third word; stream continues aligned.
        applyStimulus(0, 4'b0011, 1'b1, 64'h0002_0001, 1'b0);
        applyStimulus(0, 4'b0011, 1'b1, 64'h0004_0003, 1'b0);
        applyStimulus(0, 4'b0011, 1'b1, 64'h0006_0005, 1'b1);
        checkOutput("ovf wr",   {63'b0, wr2},   64'd0);
        checkOutput("ovf dovf", {63'b0, dovf2}, 64'd1);
        checkOutput("ovf hold", {32'b0, pd2},   64'h0004_0003);
        applyStimulus(0, 4'b0011, 1'b1, 64'h0008_0007, 1'b0);
        checkOutput("ovf resume", {32'b0, pd2},   64'h0008_0007);
        checkOutput("ovf pulse",  {63'b0, dovf2}, 64'd0);

        // A dropped word leaves sync armed.
        applyStimulus(0, 4'b0001, 1'b1, 64'h0000_0009, 1'b1);
        applyStimulus(0, 4'b0001, 1'b1, 64'h0000_000A, 1'b1);
        checkOutput("drop dovf", {63'b0, dovf2}, 64'd1);
        applyStimulus(0, 4'b0001, 1'b1, 64'h0000_000B, 1'b0);
        applyStimulus(0, 4'b0001, 1'b1, 64'h0000_000C, 1'b0);
        checkOutput("drop sync", {63'b0, sync2}, 64'd1);
        checkOutput("drop data", {32'b0, pd2},   64'h000C_000B);

        // Reset with one sample held.
        applyStimulus(0, 4'b0001, 1'b1, 64'h0000_000D, 1'b0);
        rst = 1'b1;
        applyStimulus(0, 4'b0001, 1'b1, 64'h0000_0099, 1'b0);
        checkOutput("rst data", {32'b0, pd2}, 64'd0);
        checkOutput("rst wr",   {63'b0, wr2}, 64'd0);
        rst = 1'b0;
        applyStimulus(0, 4'b0001, 1'b1, 64'h0000_000E, 1'b0);
        applyStimulus(0, 4'b0001, 1'b1, 64'h0000_000F, 1'b0);
        checkOutput("post rst data", {32'b0, pd2},   64'h000F_000E);
        checkOutput("post rst sync", {63'b0, sync2}, 64'd1);

        // Four lanes, three enabled: samples spill across words.
        applyStimulus(1, 4'b0111, 1'b1, 64'hFFFF_00A2_00A1_00A0, 1'b0);
        checkOutput("spill a wr", {63'b0, wr4}, 64'd0);
        applyStimulus(1, 4'b0111, 1'b1, 64'hFFFF_00B2_00B1_00B0, 1'b0);
        checkOutput("spill b data", pd4,            64'h00B0_00A2_00A1_00A0);
        checkOutput("spill b sync", {63'b0, sync4}, 64'd1);
        applyStimulus(1, 4'b0111, 1'b1, 64'hFFFF_00C2_00C1_00C0, 1'b0);
        checkOutput("spill c data", pd4, 64'h00C1_00C0_00B2_00B1);
        applyStimulus(1, 4'b0111, 1'b1, 64'hFFFF_00D2_00D1_00D0, 1'b0);
        checkOutput("spill d data", pd4, 64'h00D2_00D1_00D0_00C2);

        // All-zero enable ignores valid.
        applyStimulus(1, 4'b0000, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0);
        applyStimulus(1, 4'b0000, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0);
        checkOutput("zero en wr", {63'b0, wr4}, 64'd0);

        // Randomised traffic on the 4-lane instance, checked by the model.
        ren = 4'b1011;
        for (int c = 0; c < 60; c++) begin
            if (c % 12 == 0) ren = 4'($urandom_range(0, 15));
            applyStimulus(1, ren, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                          1'($urandom_range(0, 3) == 0));
        end
        applyStimulus(1, ren, 1'b0, 64'h0, 1'b0);

        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
